// File: rtl/bus_pkg.sv
// Shared constants, source-to-select-code map and FSM state type for the bus grant encoder.
// Pure definitions: no timing, no flow control.
package bus_pkg;

  localparam int NUM_SRC   = 25;
  localparam int SEL_W     = 5;
  localparam int IDLE_CODE = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } bus_state_t;

  // Sources 1 and 2 map to swapped codes; the downstream mux wires them crossed.
  function automatic int src_code(input int src);
    int code;
    case (src)
      1:       code = 3;
      2:       code = 2;
      default: code = src + 1;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: lowest set req index at or above ptr, wrapping to 0.
// Zero latency; valid low when no request bit is set.
module rr_priority_pick #(
  parameter int N     = 25,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  int               sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    sum    = 0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      sum = int'(ptr) + k;
      if (sum >= N) begin
        sum = sum - N;
      end
      idx = IDX_W'(sum);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/bus_grant_encoder.sv
// Round-robin bus arbiter with lock/hold, registered one-hot grant and encoded select.
// Latency: 1 cycle req->select/grant; no backpressure, lock keeps the grant while the holder requests.
module bus_grant_encoder #(
  parameter int                NUM_SRC   = bus_pkg::NUM_SRC,
  parameter int                SEL_W     = bus_pkg::SEL_W,
  parameter logic [SEL_W-1:0]  IDLE_CODE = SEL_W'(bus_pkg::IDLE_CODE)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_SRC-1:0] req,
  input  logic               lock,
  input  logic               err_clr,
  output logic [SEL_W-1:0]   select,
  output logic [NUM_SRC-1:0] grant,
  output logic               busy,
  output logic               conflict,
  output logic [7:0]         conflict_cnt
);

  import bus_pkg::*;

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  bus_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] holder;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;
  logic             multi_req;
  logic             keep_hold;

  rr_priority_pick #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .winner (pick_idx),
    .valid  (pick_vld)
  );

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_req = |(req & (req - NUM_SRC'(1)));
  assign keep_hold = lock && req[holder];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      holder       <= '0;
      select       <= IDLE_CODE;
      grant        <= '0;
      busy         <= 1'b0;
      conflict     <= 1'b0;
      conflict_cnt <= 8'd0;
    end else begin
      if (err_clr) begin
        conflict     <= 1'b0;
        conflict_cnt <= 8'd0;
      end else if (multi_req) begin
        conflict <= 1'b1;
        if (conflict_cnt != 8'hFF) begin
          conflict_cnt <= conflict_cnt + 8'd1;
        end
      end

      if ((state == ST_GRANT || state == ST_HOLD) && keep_hold) begin
        state <= ST_HOLD;
      end else if (pick_vld) begin
        state  <= ST_GRANT;
        holder <= pick_idx;
        select <= SEL_W'(src_code(int'(pick_idx)));
        grant  <= NUM_SRC'(1) << pick_idx;
        busy   <= 1'b1;
        if (int'(pick_idx) == NUM_SRC - 1) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= pick_idx + IDX_W'(1);
        end
      end else begin
        state  <= ST_IDLE;
        select <= IDLE_CODE;
        grant  <= '0;
        busy   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bus_grant_encoder.md
BUS_GRANT_ENCODER -- requirements
Module: bus_grant_encoder

Interface
REQ-001 Parameter NUM_SRC, default 25, number of bus source requesters.
REQ-002 Parameter SEL_W, default 5, width of the bus select code.
REQ-003 Parameter IDLE_CODE, default 0, select code driven when no source is granted.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 clr  input  1  reset, asynchronous, active-high.
REQ-006 req  input  NUM_SRC  per-source bus-drive request (bit i = source i).
REQ-007 lock  input  1  holds the current grant while the holder's req stays high.
REQ-008 err_clr  input  1  synchronous clear of the sticky conflict flag and counter.
REQ-009 select  output  SEL_W  registered select code for the downstream 32-bit bus mux.
REQ-010 grant  output  NUM_SRC  registered one-hot grant; all-zero when idle.
REQ-011 busy  output  1  high whenever a grant is active.
REQ-012 conflict  output  1  sticky: more than one req bit was seen high in one cycle.
REQ-013 conflict_cnt  output  8  saturating count of conflict cycles.

Function
REQ-014 The select code map SHALL be: source i -> code i+1, except source 1 -> code 3 and source 2 -> code 2.
REQ-015 FSM states SHALL be IDLE, GRANT and HOLD.
REQ-016 IDLE: select=IDLE_CODE, grant=0, busy=0; if any req is high, pick a winner and enter GRANT at the next edge.
REQ-017 Winner selection SHALL be round-robin: the lowest index at or above rr_ptr, wrapping to 0; rr_ptr becomes winner+1 mod NUM_SRC.
REQ-018 Latency SHALL be exactly one cycle from req sampled to select/grant/busy valid.
REQ-019 GRANT, lock=1 and holder req=1: enter HOLD and keep select/grant unchanged.
REQ-020 GRANT, lock=0: re-arbitrate; the holder competes only if its req is still high and gets no priority.
REQ-021 HOLD: keep the grant while lock=1 and holder req=1; otherwise re-arbitrate (next state GRANT) or go to IDLE if req=0.
REQ-022 GRANT or HOLD with req all-zero at re-arbitration SHALL go to IDLE with select=IDLE_CODE at the next edge.
REQ-023 Bits of req at index >= NUM_SRC SHALL be ignored, and grant SHALL never have more than one bit set.
REQ-024 A cycle with popcount(req)>1 SHALL set conflict at the next edge and increment conflict_cnt, saturating at 255.
REQ-025 If err_clr and a conflict occur in the same cycle, err_clr SHALL win: conflict=0 and conflict_cnt=0.
REQ-026 Conflicts SHALL NOT block arbitration; exactly one winner is granted per REQ-017.

Reset
REQ-027 clr=1 SHALL immediately force state=IDLE, select=IDLE_CODE, grant=0, busy=0, conflict=0, conflict_cnt=0 and rr_ptr=0, independent of clk.
REQ-028 clr asserted in the middle of a HOLD SHALL drop the grant with no completion cycle.
REQ-029 After clr deasserts, the first req SHALL be arbitrated from rr_ptr=0.

Structure
REQ-030 The shared package bus_pkg SHALL hold NUM_SRC, SEL_W, IDLE_CODE, the source-to-code table and the FSM state enum.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_priority_pick (inputs req and ptr; outputs winner index and valid).
REQ-032 All outputs SHALL be driven from flops.

Verification
REQ-033 Reset, then req=bit 4 for one cycle -> next cycle select=5, grant=bit 4, busy=1; the cycle after, select=0 and busy=0.
REQ-034 req=bit 1, then req=bit 2 -> select=3, then select=2.
REQ-035 req=bits 0,3,7 held high with lock=0 -> grants rotate 0,3,7,0 on successive cycles; conflict=1; conflict_cnt increments every cycle.
REQ-036 Grant source 5 with lock=1 while req bits 5 and 9 are high for 4 cycles -> select=6 held for 4 cycles; lock drops -> select=10 next cycle.
REQ-037 300 conflict cycles -> conflict_cnt=255; err_clr pulse concurrent with a conflict -> conflict=0 and conflict_cnt=0.
REQ-038 clr pulse mid-HOLD between clock edges -> outputs go to reset values before the next edge; the next req of bit 24 -> select=25.
